// File: rtl/mac_dot_pipe.sv
// mac_dot_pipe: pipelined fixed-point dot-product engine.
//
// One job starts with a start pulse carrying the beat count len. Each
// accepted beat supplies LANES signed operand/weight pairs. These are
// multiplied (stage 1), summed across lanes (stage 2) and added into a
// wrapping accumulator (stage 3). When the last beat has left the
// pipeline, the result is presented on out_acc/out_data. It is held with
// out_valid until out_ready takes it.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   start      begins a job (only honoured in IDLE), len sampled with it
//   len        number of beats in the job (0 gives an immediate zero result)
//   in_valid   beat valid; a beat is taken when in_valid && in_ready
//   in_ready   high in RUN while fewer than len beats have been accepted
//   in_val     packed signed operands, lane 0 in the LSBs
//   weight     packed signed weights, lane 0 in the LSBs
//   out_valid  result valid, held until taken
//   out_ready  result taken when out_valid && out_ready
//   out_acc    raw accumulator with 2*FRAC_BITS fraction bits
//   out_data   accumulator rounded (half up) to FRAC_BITS fraction bits
//   busy       high whenever the engine is not IDLE
//
// Build option: define MAC_DOT_SAT_EN to clamp out_data to the DATA_W
// signed range. Without it, out_data wraps to its low DATA_W bits.
// out_acc is identical in both builds.

module mac_dot_pipe #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 10,
  parameter int LANES     = 4,
  parameter int ACC_W     = 40,
  parameter int LEN_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_val,
  input  logic [LANES*DATA_W-1:0]   weight,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_acc,
  output logic [DATA_W-1:0]         out_data,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC_BITS - 1);

  state_t                    state;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          beat_cnt;
  logic                      drain_cnt;
  logic                      accept;

  logic signed [2*DATA_W-1:0] prod_d [LANES];
  logic signed [2*DATA_W-1:0] prod_q [LANES];
  logic                       prod_vld;
  logic signed [ACC_W-1:0]    sum_d;
  logic signed [ACC_W-1:0]    sum_q;
  logic                       sum_vld;
  logic signed [ACC_W-1:0]    acc_q;

  logic signed [ACC_W:0]      rounded;
  logic signed [ACC_W:0]      shifted;
  logic [DATA_W-1:0]          out_data_nxt;

  assign in_ready = (state == RUN) && (beat_cnt < len_q);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Lane products: operands are widened before the multiply so the full
  // 2*DATA_W signed product is kept.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod_d[l] = (2*DATA_W)'($signed(in_val[l*DATA_W +: DATA_W])) *
                  (2*DATA_W)'($signed(weight[l*DATA_W +: DATA_W]));
    end
  end

  // Lane sum, each product sign-extended to accumulator width
  always_comb begin
    sum_d = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_d = sum_d + ACC_W'(prod_q[l]);
    end
  end

  // Rescale: one extra bit so the rounding add cannot overflow, then an
  // arithmetic shift drops the extra fraction bits.
  always_comb begin
    rounded = (ACC_W+1)'(acc_q) + HALF;
    shifted = rounded >>> FRAC_BITS;
  end

`ifdef MAC_DOT_SAT_EN
  localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};

  always_comb begin
    if (shifted > (ACC_W+1)'(DMAX)) begin
      out_data_nxt = DMAX;
    end else if (shifted < (ACC_W+1)'(DMIN)) begin
      out_data_nxt = DMIN;
    end else begin
      out_data_nxt = shifted[DATA_W-1:0];
    end
  end
`else
  logic unused_bits;
  assign unused_bits  = ^shifted[ACC_W:DATA_W];
  assign out_data_nxt = shifted[DATA_W-1:0];
`endif

  // Datapath pipeline. The accumulator is cleared when a job is started,
  // and it only moves when a real beat reaches stage 3, so gaps are bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) prod_q[l] <= '0;
      prod_vld <= 1'b0;
      sum_q    <= '0;
      sum_vld  <= 1'b0;
      acc_q    <= '0;
    end else begin
      prod_vld <= accept;
      if (accept) begin
        for (int l = 0; l < LANES; l++) prod_q[l] <= prod_d[l];
      end
      sum_vld <= prod_vld;
      if (prod_vld) sum_q <= sum_d;
      if (state == IDLE && start) begin
        acc_q <= '0;
      end else if (sum_vld) begin
        acc_q <= acc_q + sum_q;
      end
    end
  end

  // Control FSM. DRAIN covers the two cycles the last beat needs to reach
  // the accumulator. DONE spends its first cycle capturing the result,
  // and it then holds it until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            beat_cnt <= '0;
            state    <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (beat_cnt + LEN_W'(1) == len_q) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_acc   <= acc_q;
            out_data  <= out_data_nxt;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_pipe.sv
// tb_mac_dot_pipe: directed bench for mac_dot_pipe with a scoreboard.
// Each job pushes its hand-computed result into a queue. A monitor pops
// and compares whenever the DUT hands over a result.

module tb_mac_dot_pipe;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [7:0]   len;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_val;
  logic [63:0]  weight;
  logic         out_valid;
  logic         out_ready;
  logic [39:0]  out_acc;
  logic [15:0]  out_data;
  logic         busy;

  typedef struct {
    logic [39:0] acc;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] beat_val [8];
  logic [63:0] beat_wt  [8];

  mac_dot_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (in_val),
    .weight    (weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: a result is consumed at the edge after out_valid && out_ready
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected result", 64'(out_acc), 64'hDEAD);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("out_acc", 64'(out_acc), 64'(mon_e.acc));
        checkOutput("out_data", 64'(out_data), 64'(mon_e.data));
      end
    end
  end

  // Runs one job from IDLE, which is entered at posedge+1.
  // beat_val/beat_wt supply the beats.
  task automatic applyStimulus(input int n, input int gap, input logic [39:0] eacc,
                               input logic [15:0] edata, input bit wait_idle,
                               input string tag);
    int   waitc;
    int   lat;
    exp_t e;
    e.acc  = eacc;
    e.data = edata;
    sb.push_back(e);
    start = 1'b1;
    len   = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_val   = beat_val[i];
      weight   = beat_wt[i];
      waitc    = 0;
      while (!in_ready && waitc < 20) begin
        @(posedge clk); #1;
        waitc++;
      end
      if (!in_ready) begin
        checkOutput({tag, " in_ready timeout"}, 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i < n - 1) begin
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
    end
    if (n > 0) checkOutput({tag, " in_ready after last beat"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " out_valid latency"}, 64'(lat), (n > 0) ? 64'd3 : 64'd1);
    if (wait_idle) begin
      waitc = 0;
      while (busy && waitc < 30) begin
        @(posedge clk); #1;
        waitc++;
      end
      checkOutput({tag, " return to idle"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_val    = '0;
    weight    = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat_val[i] = '0;
      beat_wt[i]  = '0;
    end
    #12;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_acc", 64'(out_acc), 64'd0);
    checkOutput("reset out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1.0 x 2.0 on every lane, single beat
    beat_val[0] = {4{16'h0400}};
    beat_wt[0]  = {4{16'h0800}};
    applyStimulus(1, 0, 40'h0000800000, 16'h2000, 1'b1, "unit");

    // 0.5 x -1.0, four beats back-to-back then with 2-cycle gaps
    for (int i = 0; i < 4; i++) begin
      beat_val[i] = {4{16'h0200}};
      beat_wt[i]  = {4{16'hFC00}};
    end
    applyStimulus(4, 0, 40'hFFFF800000, 16'hE000, 1'b1, "neg b2b");
    applyStimulus(4, 2, 40'hFFFF800000, 16'hE000, 1'b1, "neg gap");

    // Mixed lanes: 1*1 + (-2)*1 + 0.25*4 + 3*(-1) = -3.0
    beat_val[0] = {16'h0C00, 16'h0100, 16'hF800, 16'h0400};
    beat_wt[0]  = {16'hFC00, 16'h1000, 16'h0400, 16'h0400};
    applyStimulus(1, 0, 40'hFFFFD00000, 16'hF400, 1'b1, "mixed");

    // Two distinct beats: 8.0 + (-3.0) = 5.0
    beat_val[1] = beat_val[0];
    beat_wt[1]  = beat_wt[0];
    beat_val[0] = {4{16'h0400}};
    beat_wt[0]  = {4{16'h0800}};
    applyStimulus(2, 1, 40'h0000500000, 16'h1400, 1'b1, "two beats");

    // Rounding boundaries around half an output LSB
    beat_val[0] = {48'h0, 16'h0001};
    beat_wt[0]  = {48'h0, 16'h0200};
    applyStimulus(1, 0, 40'h0000000200, 16'h0001, 1'b1, "round half");
    beat_wt[0]  = {48'h0, 16'h01FF};
    applyStimulus(1, 0, 40'h00000001FF, 16'h0000, 1'b1, "round below");
    beat_wt[0]  = {48'h0, 16'hFDFF};
    applyStimulus(1, 0, 40'hFFFFFFFDFF, 16'hFFFF, 1'b1, "round neg");

    // Largest positive operands: rescaled value exceeds 16 bits
    for (int i = 0; i < 8; i++) begin
      beat_val[i] = {4{16'h7FFF}};
      beat_wt[i]  = {4{16'h7FFF}};
    end
`ifdef MAC_DOT_SAT_EN
    applyStimulus(8, 0, 40'h07FFE00020, 16'h7FFF, 1'b1, "overflow");
`else
    applyStimulus(8, 0, 40'h07FFE00020, 16'hF800, 1'b1, "overflow");
`endif

    // Zero-length job, held result, start during the handshake ignored
    out_ready = 1'b0;
    applyStimulus(0, 0, 40'h0, 16'h0, 1'b0, "len0");
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("len0 out_valid held", 64'(out_valid), 64'd1);
      checkOutput("len0 out_acc held", 64'(out_acc), 64'd0);
      checkOutput("len0 out_data held", 64'(out_data), 64'd0);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("start at handshake ignored", 64'(busy), 64'd0);
    checkOutput("out_valid cleared", 64'(out_valid), 64'd0);

    // Reset mid-job after two beats of four
    beat_val[0] = {4{16'h0400}};
    beat_wt[0]  = {4{16'h0800}};
    start = 1'b1;
    len   = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_val   = beat_val[0];
    weight   = beat_wt[0];
    repeat (2) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("mid reset busy", 64'(busy), 64'd0);
    checkOutput("mid reset in_ready", 64'(in_ready), 64'd0);
    checkOutput("mid reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid reset out_acc", 64'(out_acc), 64'd0);
    checkOutput("mid reset out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      checkOutput("no stale result", 64'(out_valid), 64'd0);
    end
    beat_val[0] = {16'h0C00, 16'h0100, 16'hF800, 16'h0400};
    beat_wt[0]  = {16'hFC00, 16'h1000, 16'h0400, 16'h0400};
    applyStimulus(1, 0, 40'hFFFFD00000, 16'hF400, 1'b1, "after reset");

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_dot_pipe.md
MAC_DOT_PIPE -- requirements
Module: mac_dot_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand width (signed S5.10 at default).
REQ-002 SHALL have parameter FRAC_BITS, default 10, operand fraction bits; product fraction = 2*FRAC_BITS.
REQ-003 SHALL have parameter LANES, default 4, parallel multiplies per beat (power of two, >=1).
REQ-004 SHALL have parameter ACC_W, default 40, accumulator width (>= 2*DATA_W + clog2(LANES)).
REQ-005 SHALL have parameter LEN_W, default 8, beat-count width.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  input  1  pulse that begins one dot-product job.
REQ-009 SHALL have port len  input  LEN_W  number of beats in the job, sampled with start.
REQ-010 SHALL have port in_valid  input  1  beat valid.
REQ-011 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-012 SHALL have port in_val  input  LANES*DATA_W  packed signed operands, lane 0 in LSBs.
REQ-013 SHALL have port weight  input  LANES*DATA_W  packed signed weights, lane 0 in LSBs.
REQ-014 SHALL have port out_valid  output  1  result valid, held until taken.
REQ-015 SHALL have port out_ready  input  1  result taken when out_valid && out_ready.
REQ-016 SHALL have port out_acc  output  ACC_W  raw accumulator, 2*FRAC_BITS fraction bits.
REQ-017 SHALL have port out_data  output  DATA_W  accumulator rescaled to FRAC_BITS fraction bits.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; busy = (state != IDLE).
REQ-020 IDLE: start with len>0 -> RUN; start with len==0 -> DONE with out_acc=0; accumulator cleared on start.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 in_ready SHALL be 1 only in RUN and while accepted-beat count < len.
REQ-023 Pipeline per accepted beat: stage 1 registers LANES signed products (2*DATA_W each); stage 2 registers sign-extended lane sum; stage 3 adds sum into accumulator.
REQ-024 Beats may arrive on consecutive cycles; gaps (in_valid low) SHALL insert bubbles with no accumulation.
REQ-025 After beat number len accepted: RUN -> DRAIN; DRAIN lasts exactly 2 cycles; then DONE.
REQ-026 Last beat accepted at edge N -> out_valid high after edge N+3.
REQ-027 DONE: out_valid=1, out_acc/out_data stable until handshake; handshake -> IDLE with out_valid=0 next cycle.
REQ-028 start in same cycle as the DONE handshake SHALL be ignored (IDLE entered first).
REQ-029 Accumulator SHALL wrap modulo 2^ACC_W; no internal saturation.
REQ-030 out_data = (out_acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half up, arithmetic shift), then narrowed per REQ-034/035.

Reset
REQ-031 rst_n low SHALL asynchronously force state=IDLE, in_ready=0, out_valid=0, busy=0, out_acc=0, out_data=0, beat count and all pipeline registers 0.
REQ-032 Reset mid-job SHALL discard the job; no out_valid after release until a new start completes.
REQ-033 First start is honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-034 With MAC_DOT_SAT_EN defined: rescaled value outside DATA_W signed range SHALL clamp to 2^(DATA_W-1)-1 or -2^(DATA_W-1).
REQ-035 Without MAC_DOT_SAT_EN: out_data SHALL be the low DATA_W bits of the rescaled value (two's-complement wrap); out_acc identical in both builds.

Verification
REQ-036 Defaults, len=1, lanes all 1.0 (0x0400) x 2.0 (0x0800) -> out_acc=0x0800000 (8.0), out_data=0x2000, out_valid 3 cycles after beat.
REQ-037 len=4, beats back-to-back then with 2-cycle gaps, lanes 0.5 x -1.0 -> out_data=0xE000 (-8.0) both runs; in_ready drops after beat 4.
REQ-038 len=0 start -> DONE next cycle, out_acc=0, out_data=0; out_ready held low 5 cycles -> out_valid stays 1, data stable.
REQ-039 len=8, all lanes 0x7FFF x 0x7FFF -> with MAC_DOT_SAT_EN out_data=0x7FFF; without, out_data = low 16 bits of rounded shift.
REQ-040 rst_n low after beat 2 of len=4 -> all outputs 0 immediately; new len=1 job afterward yields only the new result.
